mem_access: RTL
===============

// Module: mem_access
// PURPOSE
// - MEM stage directly downstream of execution: takes registered load/store requests, runs a req/ack data-bus transaction.
// - Aligns and extends load data and drives register writeback; builds store byte strobes.
// - Holds the pipeline via pause_signal while a transaction is outstanding.
// PARAMETERS
// - XLEN            32   data/address width
// - TIMEOUT_CYCLES  255  max cycles in REQ waiting for bus_ack before abort (>=1)
// - TIMEOUT_W       8    width of timeout counter, must hold TIMEOUT_CYCLES
// PORTS
// - clk                 in   1       rising-edge clock
// - rst_n               in   1       synchronous reset, active low
// - mem_load_en         in   1       load request from execution stage (registered)
// - mem_load_addr       in   XLEN    load byte address
// - mem_load_regs_addr  in   5       load destination register
// - mem_store_en        in   1       store request
// - mem_store_addr      in   XLEN    store byte address
// - mem_store_data      in   XLEN    store data (rs2)
// - mem_funct3          in   3       access size/sign: 000 B,001 H,010 W,100 BU,101 HU
// - bus_req / bus_we    out  1       request valid / write
// - bus_addr            out  XLEN    word-aligned address ({addr[XLEN-1:2],2'b00})
// - bus_wdata           out  XLEN    store data replicated per lane
// - bus_wstrb           out  4       byte lane enables (0 on reads)
// - bus_ack             in   1       transaction complete; bus_rdata valid same cycle
// - bus_rdata           in   XLEN    read word
// - regs_write_en       out  1       writeback pulse
// - regs_write_addr     out  5       writeback register
// - regs_write_data     out  XLEN    extended load data
// - pause_signal        out  1       stall upstream stages
// - bus_error           out  1       1-cycle pulse on timeout abort
// - misalign_fault      out  1       1-cycle pulse, see CONFIGURATION
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction: bus_req drops at that edge, no writeback, no error pulse.
// - FSM IDLE -> REQ -> DONE -> IDLE. IDLE: on load_en|store_en capture addr/data/rd/funct3, go REQ next edge.
// - Both enables high: load wins, store dropped.
// - REQ: bus_req=1, bus_addr/we/wdata/wstrb stable until ack. On bus_ack: latch aligned data, go DONE.
// - Counter increments each REQ cycle without ack; reaching TIMEOUT_CYCLES -> abort to IDLE, bus_error pulse, no writeback.
// - DONE (1 cycle): load -> regs_write_en=1 with rd/data; suppressed when rd==0. Store -> no writeback. Then IDLE.
// - Latency: request in cycle N, bus_req from N+1; ack in cycle M -> writeback visible in M+1.
// - pause_signal (combinational) = (IDLE & (load_en|store_en)) | REQ; low in DONE so next instruction advances there.
// - A new request may be accepted in IDLE only; nothing is accepted in DONE (upstream still paused-to-release).
// - Load: off=addr[1:0]; B/BU take byte off, H/HU take half addr[1]; sign-extend B/H, zero-extend BU/HU; W whole word.
// - Store strobe: SB 4'b0001<<off, SH 4'b0011<<{addr[1],1'b0}, SW 4'b1111; wdata = byte x4 / half x2 / word.
// - funct3 011,110,111: treated as W.
// CONFIGURATION
// - MEM_ACCESS_MISALIGN_TRAP_EN defined: H/HU/SH with addr[0]=1 or W/SW with addr[1:0]!=0 -> no bus transaction, misalign_fault 1-cycle pulse in the cycle after capture, no writeback, back to IDLE; pause held through that cycle.
// - Not defined: misalign_fault tied 0; misaligned offset bits ignored (H uses addr[1], W uses lane 0), access proceeds normally.
// STRUCTURE
// - Shared package define/mem.v: funct3 size codes, FSM state encodings, strobe constants; reuse existing `true/`false, `XLEN_WIDTH, `REG_ADDR.
// - Sub-module mem_lane_align: combinational load extract/extend and store strobe/replication; FSM and counter stay in mem_access.
// TESTING
// - LW 0x100, ack after 3 cycles rdata=0xDEADBEEF, rd=5 -> bus_req 3 cycles, regs_write_en 1 cycle rd=5 data=0xDEADBEEF, pause low in DONE.
// - LB addr 0x103 rdata=0x80FF_0000 -> data 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
// - SB 0x201 data 0x000000AB -> bus_we=1, bus_addr 0x200, wstrb 0001<<1=0010, wdata 0xABABABAB; no writeback.
// - No ack, TIMEOUT_CYCLES=4 -> bus_req 4 cycles, bus_error 1 pulse, regs_write_en stays 0, FSM IDLE.
// - LW to rd=0 -> bus transaction, regs_write_en stays 0; load_en & store_en together -> read only.
// - rst_n low during REQ -> bus_req 0 next edge, no writeback; with macro: LW 0x102 -> misalign_fault pulse, no bus_req.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM stage: FSM states, funct3 size codes, strobe patterns.
package mem_access_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone,
    StFault
  } mem_state_e;

  // funct3[1:0] selects access size; funct3[2] selects zero-extension on loads.
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;

  localparam logic [3:0] StrbByte = 4'b0001;
  localparam logic [3:0] StrbHalf = 4'b0011;
  localparam logic [3:0] StrbWord = 4'b1111;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      SizeByte: return 1'b0;
      SizeHalf: return off[0];
      default:  return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: load extract/extend and store strobe/replication.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_off,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load_data,
  output logic [XLEN-1:0] o_wdata,
  output logic [3:0]      o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unsigned;

  assign w_byte     = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half     = i_rdata[{i_off[1], 4'b0000} +: 16];
  assign w_unsigned = i_funct3[2];

  always_comb begin
    o_load_data = i_rdata;
    o_wdata     = i_wdata;
    o_wstrb     = StrbWord;
    case (i_funct3[1:0])
      SizeByte: begin
        o_load_data = {{(XLEN-8){~w_unsigned & w_byte[7]}}, w_byte};
        o_wdata     = {(XLEN/8){i_wdata[7:0]}};
        o_wstrb     = StrbByte << i_off;
      end
      SizeHalf: begin
        o_load_data = {{(XLEN-16){~w_unsigned & w_half[15]}}, w_half};
        o_wdata     = {(XLEN/16){i_wdata[15:0]}};
        o_wstrb     = StrbHalf << {i_off[1], 1'b0};
      end
      default: begin
        o_load_data = i_rdata;
        o_wdata     = i_wdata;
        o_wstrb     = StrbWord;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: single outstanding req/ack bus transaction per load/store, with timeout abort.
// Optional misaligned-access trap enabled by defining MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mem_load_en,
  input  logic [XLEN-1:0] i_mem_load_addr,
  input  logic [4:0]      i_mem_load_regs_addr,
  input  logic            i_mem_store_en,
  input  logic [XLEN-1:0] i_mem_store_addr,
  input  logic [XLEN-1:0] i_mem_store_data,
  input  logic [2:0]      i_mem_funct3,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [3:0]      o_bus_wstrb,
  input  logic            i_bus_ack,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic            o_regs_write_en,
  output logic [4:0]      o_regs_write_addr,
  output logic [XLEN-1:0] o_regs_write_data,
  output logic            o_pause_signal,
  output logic            o_bus_error,
  output logic            o_misalign_fault
);

  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e           r_state, w_state_d;
  logic [TIMEOUT_W-1:0] r_cnt, w_cnt_d;
  logic                 r_bus_error, w_bus_error_d;
  logic                 r_is_load;
  logic [XLEN-1:0]      r_addr;
  logic [XLEN-1:0]      r_wdata;
  logic [4:0]           r_rd;
  logic [2:0]           r_funct3;
  logic [XLEN-1:0]      r_load_data;

  logic            w_start;
  logic            w_capture;
  logic [XLEN-1:0] w_sel_addr;
  logic            w_misalign;
  logic            w_in_req;
  logic            w_store_req;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_wstrb;

  // Load has priority; a simultaneous store is dropped.
  assign w_start    = i_mem_load_en | i_mem_store_en;
  assign w_capture  = (r_state == StIdle) & w_start;
  assign w_sel_addr = i_mem_load_en ? i_mem_load_addr : i_mem_store_addr;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign w_misalign       = is_misaligned(i_mem_funct3, w_sel_addr[1:0]);
  assign o_misalign_fault = (r_state == StFault);
`else
  assign w_misalign       = 1'b0;
  assign o_misalign_fault = 1'b0;
`endif

  mem_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .i_funct3   (r_funct3),
    .i_off      (r_addr[1:0]),
    .i_rdata    (i_bus_rdata),
    .i_wdata    (r_wdata),
    .o_load_data(w_load_data),
    .o_wdata    (w_wdata),
    .o_wstrb    (w_wstrb)
  );

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_bus_error_d = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = w_misalign ? StFault : StReq;
        end
      end
      StReq: begin
        if (i_bus_ack) begin
          w_state_d = StDone;
          w_cnt_d   = '0;
        end else if (r_cnt == TimeoutLast) begin
          w_state_d     = StIdle;
          w_cnt_d       = '0;
          w_bus_error_d = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone:  w_state_d = StIdle;
      StFault: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bus_error <= 1'b0;
      r_is_load   <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_funct3    <= '0;
      r_load_data <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_bus_error <= w_bus_error_d;
      if (w_capture) begin
        r_is_load <= i_mem_load_en;
        r_addr    <= w_sel_addr;
        r_wdata   <= i_mem_store_data;
        r_rd      <= i_mem_load_regs_addr;
        r_funct3  <= i_mem_funct3;
      end
      if ((r_state == StReq) && i_bus_ack) begin
        r_load_data <= w_load_data;
      end
    end
  end

  assign w_in_req    = (r_state == StReq);
  assign w_store_req = w_in_req & ~r_is_load;

  assign o_bus_req   = w_in_req;
  assign o_bus_we    = w_store_req;
  assign o_bus_addr  = w_in_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign o_bus_wdata = w_store_req ? w_wdata : '0;
  assign o_bus_wstrb = w_store_req ? w_wstrb : 4'b0000;

  // Writeback to x0 is suppressed but the bus transaction still happens.
  assign o_regs_write_en   = (r_state == StDone) & r_is_load & (r_rd != 5'd0);
  assign o_regs_write_addr = o_regs_write_en ? r_rd : 5'd0;
  assign o_regs_write_data = o_regs_write_en ? r_load_data : '0;

  assign o_pause_signal = ((r_state == StIdle) & w_start) | w_in_req | (r_state == StFault);
  assign o_bus_error    = r_bus_error;

endmodule
